// File: rtl/costas_discriminator.sv
// Integrate-and-dump Costas discriminator: accumulates valid I/Q samples
// over N samples, dumps prompt sums, phase error, data bit and lock flag.
//
// Ports:
//   clk, rst      clock, async active-high reset
//   in_valid      qualifies in_i/in_q
//   in_i, in_q    signed wiped-off samples (IN_W)
//   mode          0: I*Q, 1: sign(I)*Q, 2: I*sign(Q), 3: as 0
//   sum_valid     one-cycle pulse with new sum_i/sum_q/data_bit
//   sum_i, sum_q  dumped saturated sums (ACC_W)
//   err_valid     one-cycle pulse with new phase_error
//   phase_error   signed discriminator output (2*ACC_W)
//   data_bit      1 when dumped sum_i >= 0
//   lock          hysteretic carrier-lock flag
module costas_discriminator #(
    parameter int IN_W       = 16,
    parameter int ACC_W      = 32,
    parameter int N          = 10000,
    parameter int LOCK_SHIFT = 1,
    parameter int LOCK_CNT   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IN_W-1:0]      in_i,
    input  logic [IN_W-1:0]      in_q,
    input  logic [1:0]           mode,
    output logic                 sum_valid,
    output logic [ACC_W-1:0]     sum_i,
    output logic [ACC_W-1:0]     sum_q,
    output logic                 err_valid,
    output logic [2*ACC_W-1:0]   phase_error,
    output logic                 data_bit,
    output logic                 lock
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int MW = ACC_W + LOCK_SHIFT + 1;
    localparam int PW = 2 * ACC_W;

    localparam logic [CW-1:0]    LAST  = CW'(N - 1);
    localparam logic [LW-1:0]    LC_HI = LW'(LOCK_CNT);
    localparam logic [ACC_W-1:0] MAXV  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MINV  = {1'b1, {(ACC_W-1){1'b0}}};

    // Add in ACC_W+1 bits; disagreeing top bits mean overflow, clamp.
    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b
    );
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            sat_add = s[ACC_W] ? MINV : MAXV;
        else
            sat_add = s[ACC_W-1:0];
    endfunction

    logic [CW-1:0]    r_cnt;
    logic [ACC_W-1:0] r_acc_i;
    logic [ACC_W-1:0] r_acc_q;
    logic [ACC_W-1:0] r_sum_i;
    logic [ACC_W-1:0] r_sum_q;
    logic             r_sum_valid;
    logic             r_data_bit;
    logic             r_err_valid;
    logic [PW-1:0]    r_pe;
    logic [LW-1:0]    r_lc;
    logic             r_lock;

    logic [ACC_W-1:0] w_ext_i;
    logic [ACC_W-1:0] w_ext_q;
    logic [ACC_W-1:0] w_nxt_i;
    logic [ACC_W-1:0] w_nxt_q;

    assign w_ext_i = ACC_W'($signed(in_i));
    assign w_ext_q = ACC_W'($signed(in_q));
    assign w_nxt_i = sat_add(r_acc_i, w_ext_i);
    assign w_nxt_q = sat_add(r_acc_q, w_ext_q);

    // Integrate stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            r_sum_i     <= '0;
            r_sum_q     <= '0;
            r_sum_valid <= 1'b0;
            r_data_bit  <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (in_valid) begin
                if (r_cnt == LAST) begin
                    r_cnt       <= '0;
                    r_acc_i     <= '0;
                    r_acc_q     <= '0;
                    r_sum_i     <= w_nxt_i;
                    r_sum_q     <= w_nxt_q;
                    r_data_bit  <= ~w_nxt_i[ACC_W-1];
                    r_sum_valid <= 1'b1;
                end else begin
                    r_cnt   <= r_cnt + CW'(1);
                    r_acc_i <= w_nxt_i;
                    r_acc_q <= w_nxt_q;
                end
            end
        end
    end

    // Discriminator
    logic [ACC_W-1:0]     w_neg_i;
    logic [ACC_W-1:0]     w_neg_q;
    logic [ACC_W-1:0]     w_sel;
    logic signed [PW-1:0] w_pi;
    logic signed [PW-1:0] w_pq;
    logic signed [PW-1:0] w_prod;
    logic [PW-1:0]        w_pe;

    // Negating the most negative value clamps to the most positive.
    assign w_neg_i = (r_sum_i == MINV) ? MAXV : (~r_sum_i + ACC_W'(1));
    assign w_neg_q = (r_sum_q == MINV) ? MAXV : (~r_sum_q + ACC_W'(1));
    assign w_pi    = PW'($signed(r_sum_i));
    assign w_pq    = PW'($signed(r_sum_q));
    assign w_prod  = w_pi * w_pq;

    always_comb begin
        w_sel = r_sum_q;
        w_pe  = w_prod;
        case (mode)
            2'd1: begin
                w_sel = r_sum_i[ACC_W-1] ? w_neg_q : r_sum_q;
                w_pe  = PW'($signed(w_sel));
            end
            2'd2: begin
                w_sel = r_sum_q[ACC_W-1] ? w_neg_i : r_sum_i;
                w_pe  = PW'($signed(w_sel));
            end
            default: w_pe = w_prod;
        endcase
    end

    // Lock detector magnitudes, wide enough for |MIN| << LOCK_SHIFT.
    logic [MW-1:0] w_si;
    logic [MW-1:0] w_sq;
    logic [MW-1:0] w_a;
    logic [MW-1:0] w_aq;
    logic [MW-1:0] w_b;
    logic [LW-1:0] w_lc_nxt;

    assign w_si = MW'($signed(r_sum_i));
    assign w_sq = MW'($signed(r_sum_q));
    assign w_a  = w_si[MW-1] ? (~w_si + MW'(1)) : w_si;
    assign w_aq = w_sq[MW-1] ? (~w_sq + MW'(1)) : w_sq;
    assign w_b  = w_aq << LOCK_SHIFT;

    always_comb begin
        w_lc_nxt = r_lc;
        if (w_a >= w_b) begin
            if (r_lc != LC_HI)
                w_lc_nxt = r_lc + LW'(1);
        end else begin
            if (r_lc != '0)
                w_lc_nxt = r_lc - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_valid <= 1'b0;
            r_pe        <= '0;
            r_lc        <= '0;
            r_lock      <= 1'b0;
        end else begin
            r_err_valid <= r_sum_valid;
            if (r_sum_valid) begin
                r_pe <= w_pe;
                r_lc <= w_lc_nxt;
                if (w_lc_nxt == LC_HI)
                    r_lock <= 1'b1;
                else if (w_lc_nxt == '0)
                    r_lock <= 1'b0;
            end
        end
    end

    assign sum_valid   = r_sum_valid;
    assign sum_i       = r_sum_i;
    assign sum_q       = r_sum_q;
    assign data_bit    = r_data_bit;
    assign err_valid   = r_err_valid;
    assign phase_error = r_pe;
    assign lock        = r_lock;

endmodule
